mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl.sv | 103 ++++++++++
 tb/tb_mult_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing controller for a shared matrix-vector multiplier: arbitrates two
// requesters round-robin, loads operands, waits out the multiplier latency and hands off the result.
module mult_ctrl #(
    parameter int N   = 3,
    parameter int LAT = (N > 2) ? N : 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       ld_en,
    output logic       mult_reset_n,
    output logic       busy,
    output logic       res_valid,
    output logic       res_id,
    input  logic       res_ready
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            sel_reg, sel_next;
    logic            last_reg, last_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            mult_reset_n_reg;
    logic            winner;

    // On a tie the requester that was not served most recently wins.
    assign winner = (req[0] && req[1]) ? ~last_reg : req[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            sel_reg          <= 1'b0;
            last_reg         <= 1'b1;
            cnt_reg          <= '0;
            mult_reset_n_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            sel_reg          <= sel_next;
            last_reg         <= last_next;
            cnt_reg          <= cnt_next;
            mult_reset_n_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next = LOAD;
                    sel_next   = winner;
                end
            end
            LOAD: begin
                state_next = WAIT;
                cnt_next   = CW'(LAT);
            end
            WAIT: begin
                // Counter saturates at zero; it is only reloaded on LOAD.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end
                if (cnt_reg == CW'(1)) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (res_ready) begin
                    state_next = IDLE;
                    last_next  = sel_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg == LOAD) && (sel_reg == 1'(gi));
        end
    endgenerate

    assign sel          = sel_reg;
    assign ld_en        = (state_reg == LOAD);
    assign busy         = (state_reg != IDLE);
    assign res_valid    = (state_reg == VALID);
    assign res_id       = sel_reg;
    assign mult_reset_n = mult_reset_n_reg;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: N=3 main instance plus N=1 and N=8 instances
// sharing the same stimulus to check latency scaling.
module tb_mult_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic       res_ready = 1'b1;

    logic [1:0] gnt3, gnt1, gnt8;
    logic       sel3, sel1, sel8;
    logic       ld3, ld1, ld8;
    logic       mrn3, mrn1, mrn8;
    logic       busy3, busy1, busy8;
    logic       rv3, rv1, rv8;
    logic       rid3, rid1, rid8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_ctrl #(.N(3)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt3), .sel(sel3), .ld_en(ld3),
        .mult_reset_n(mrn3), .busy(busy3), .res_valid(rv3), .res_id(rid3), .res_ready(res_ready)
    );
    mult_ctrl #(.N(1)) dut_n1 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .sel(sel1), .ld_en(ld1),
        .mult_reset_n(mrn1), .busy(busy1), .res_valid(rv1), .res_id(rid1), .res_ready(res_ready)
    );
    mult_ctrl #(.N(8)) dut_n8 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt8), .sel(sel8), .ld_en(ld8),
        .mult_reset_n(mrn8), .busy(busy8), .res_valid(rv8), .res_id(rid8), .res_ready(res_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int fv3, fv1, fv8, nv3, nld3;
    int ng, nr, cyc;
    logic [1:0] gv [4];
    int gc [4];
    logic rvid [4];

    initial begin
        // Reset state
        reset = 1'b1; req = 2'b00; res_ready = 1'b1;
        tick(); tick();
        chk("rst_gnt", 32'(gnt3), 0);
        chk("rst_ld_en", 32'(ld3), 0);
        chk("rst_busy", 32'(busy3), 0);
        chk("rst_res_valid", 32'(rv3), 0);
        chk("rst_sel", 32'(sel3), 0);
        chk("rst_res_id", 32'(rid3), 0);
        chk("rst_mult_reset_n", 32'(mrn3), 0);
        reset = 1'b0;
        tick();
        chk("rel_mult_reset_n", 32'(mrn3), 1);
        $display("reset sequence done");

        // Single request from requester 0, latency for LAT=3/2/8
        req = 2'b01;
        tick();
        req = 2'b00;
        chk("t1_gnt", 32'(gnt3), 1);
        chk("t1_ld_en", 32'(ld3), 1);
        chk("t1_busy", 32'(busy3), 1);
        fv3 = -1; fv1 = -1; fv8 = -1; nv3 = 0; nld3 = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rv3) begin
                if (fv3 < 0) fv3 = k;
                nv3++;
                chk("t1_res_id", 32'(rid3), 0);
            end
            if (rv1 && fv1 < 0) fv1 = k;
            if (rv8 && fv8 < 0) fv8 = k;
            if (ld3) nld3++;
        end
        chk("t1_lat_n3", 32'(fv3), 4);
        chk("t1_lat_n1", 32'(fv1), 3);
        chk("t1_lat_n8", 32'(fv8), 9);
        chk("t1_valid_cycles", 32'(nv3), 1);
        chk("t1_ld_en_cycles", 32'(nld3), 1);
        chk("t1_busy_after", 32'(busy3), 0);
        $display("single request: lat n3=%0d n1=%0d n8=%0d", fv3, fv1, fv8);

        // Both requesting continuously: alternating grants every LAT+3 cycles
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; req = 2'b11; res_ready = 1'b1;
        ng = 0; nr = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) chk("t2_mult_reset_n", 32'(mrn3), 1);
            if (gnt3 != 2'b00 && ng < 4) begin
                gv[ng] = gnt3; gc[ng] = k; ng++;
            end
            if (rv3 && nr < 4) begin
                rvid[nr] = rid3; nr++;
            end
        end
        req = 2'b00;
        chk("t2_grant_count", 32'(ng), 4);
        chk("t2_gnt0", 32'(gv[0]), 1);
        chk("t2_gnt1", 32'(gv[1]), 2);
        chk("t2_gnt2", 32'(gv[2]), 1);
        chk("t2_gnt3", 32'(gv[3]), 2);
        chk("t2_first_grant_cycle", 32'(gc[0]), 1);
        for (int i = 1; i < 4; i++) chk("t2_interval", 32'(gc[i] - gc[i-1]), 6);
        chk("t2_res_id0", 32'(rvid[0]), 0);
        chk("t2_res_id1", 32'(rvid[1]), 1);
        chk("t2_res_id2", 32'(rvid[2]), 0);
        chk("t2_res_id3", 32'(rvid[3]), 1);
        $display("round robin: grants %0d %0d %0d %0d", gv[0], gv[1], gv[2], gv[3]);

        // Backpressure in VALID
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; req = 2'b01; res_ready = 1'b0;
        tick();
        req = 2'b00;
        cyc = 0;
        while (!rv3 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t3_valid_reached", 32'(rv3), 1);
        req = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_res_valid_hold", 32'(rv3), 1);
            chk("t3_res_id_hold", 32'(rid3), 0);
            chk("t3_sel_hold", 32'(sel3), 0);
            chk("t3_ld_en_hold", 32'(ld3), 0);
            chk("t3_gnt_hold", 32'(gnt3), 0);
        end
        res_ready = 1'b1;
        tick();
        chk("t3_after_hs_valid", 32'(rv3), 0);
        chk("t3_after_hs_busy", 32'(busy3), 0);
        tick();
        chk("t3_new_gnt", 32'(gnt3), 2);
        chk("t3_new_sel", 32'(sel3), 1);
        req = 2'b00;
        $display("backpressure: result held, then gnt=%0d", gnt3);

        // Reset mid-WAIT aborts, tie after release goes to requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0; req = 2'b01;
        tick();
        req = 2'b00;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t4_gnt", 32'(gnt3), 0);
        chk("t4_ld_en", 32'(ld3), 0);
        chk("t4_busy", 32'(busy3), 0);
        chk("t4_res_valid", 32'(rv3), 0);
        chk("t4_sel", 32'(sel3), 0);
        chk("t4_res_id", 32'(rid3), 0);
        chk("t4_mult_reset_n", 32'(mrn3), 0);
        req = 2'b11;
        tick();
        reset = 1'b0;
        tick();
        chk("t4_release_gnt", 32'(gnt3), 1);
        chk("t4_release_mult_reset_n", 32'(mrn3), 1);
        req = 2'b00;
        nv3 = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rv3) nv3++;
        end
        chk("t4_results_after_release", 32'(nv3), 1);
        $display("reset abort: release grant ok, results=%0d", nv3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
